median_window_fifo: RTL and testbench

- Input-side delay line for the systolic median array.
- Takes one new sample per valid cycle and broadcasts it as X to every median cell.
- Also supplies R_old, the sample leaving the window: the value written W samples earlier.
- Cells compare R_old against their stored R to produce Z, so this block is the upstream stage that feeds medianCell_leftMst and all other cells.

---
 rtl/median_window_fifo_pkg.sv | 7 +
 rtl/median_window_fifo_window_ram.sv | 24 ++
 rtl/median_window_fifo.sv | 109 ++++++++++
 tb/tb_median_window_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/median_window_fifo_pkg.sv
// Shared sizing defaults for the median window input stage.
// Mirrors the project-wide sample width and window depth settings.
package median_window_fifo_pkg;
  localparam int DATA_LENGTH_DEF = 32;
  localparam int WMAX_DEF        = 16;
  localparam int LOG_WMAX_DEF    = 4;
endpackage

// File: rtl/median_window_fifo_window_ram.sv
// Window sample storage: one address, synchronous read-before-write.
// Read and write happen only on accepted samples so dout holds otherwise.
module window_ram #(
  parameter int DATA_LENGTH = 32,
  parameter int WMAX        = 16,
  parameter int LOG_WMAX    = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LOG_WMAX-1:0]    addr,
  input  logic [DATA_LENGTH-1:0] din,
  output logic [DATA_LENGTH-1:0] dout
);

  logic [DATA_LENGTH-1:0] mem [WMAX];

  always_ff @(posedge clk) begin
    if (we) begin
      dout      <= mem[addr];
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/median_window_fifo.sv
// Input delay line for the systolic median array: broadcasts X
// and returns R_old, the sample written W_reg accepted samples earlier.
module median_window_fifo
  import median_window_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int WMAX        = WMAX_DEF,
  parameter int LOG_WMAX    = LOG_WMAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] X_in,
  input  logic                   in_valid,
  input  logic [LOG_WMAX:0]      W,
  output logic [DATA_LENGTH-1:0] X,
  output logic [DATA_LENGTH-1:0] R_old,
  output logic                   sample_valid,
  output logic                   primed
);

  typedef enum logic {FILL, STEADY} state_e;

  localparam logic [LOG_WMAX:0] WMAX_W = (LOG_WMAX+1)'(WMAX);
  localparam logic [LOG_WMAX:0] ONE_W  = (LOG_WMAX+1)'(1);

  state_e                 state_q, state_d;
  logic [LOG_WMAX:0]      w_reg_q, w_reg_d;
  logic [LOG_WMAX:0]      fill_cnt_q, fill_cnt_d;
  logic [LOG_WMAX-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DATA_LENGTH-1:0] x_q, x_d;
  logic                   zero_q, zero_d;
  logic                   sv_q, sv_d;
  logic                   primed_q, primed_d;

  logic                   accept;
  logic [LOG_WMAX:0]      w_m1;
  logic [LOG_WMAX-1:0]    w_last;
  logic [LOG_WMAX:0]      fill_inc;
  logic [DATA_LENGTH-1:0] ram_dout;

  assign accept   = in_valid & ~reset;
  assign w_m1     = w_reg_q - ONE_W;
  assign w_last   = w_m1[LOG_WMAX-1:0];
  assign fill_inc = fill_cnt_q + ONE_W;

  always_comb begin
    state_d    = state_q;
    w_reg_d    = w_reg_q;
    fill_cnt_d = fill_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    x_d        = x_q;
    zero_d     = zero_q;
    sv_d       = 1'b0;
    primed_d   = primed_q;
    if (reset) begin
      w_reg_d    = (W == '0 || W > WMAX_W) ? WMAX_W : W;
      state_d    = FILL;
      fill_cnt_d = '0;
      wr_ptr_d   = '0;
      x_d        = '0;
      zero_d     = 1'b1;
      primed_d   = 1'b0;
    end else if (in_valid) begin
      sv_d     = 1'b1;
      x_d      = X_in;
      wr_ptr_d = (wr_ptr_q == w_last) ? '0 : wr_ptr_q + 1'b1;
      if (state_q == FILL) begin
        // Cells start out holding zeros, so the leaving sample is zero
        zero_d     = 1'b1;
        fill_cnt_d = fill_inc;
        if (fill_inc == w_reg_q) begin
          state_d  = STEADY;
          primed_d = 1'b1;
        end
      end else begin
        zero_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    w_reg_q    <= w_reg_d;
    fill_cnt_q <= fill_cnt_d;
    wr_ptr_q   <= wr_ptr_d;
    x_q        <= x_d;
    zero_q     <= zero_d;
    sv_q       <= sv_d;
    primed_q   <= primed_d;
  end

  window_ram #(
    .DATA_LENGTH(DATA_LENGTH),
    .WMAX       (WMAX),
    .LOG_WMAX   (LOG_WMAX)
  ) u_ram (
    .clk (clk),
    .we  (accept),
    .addr(wr_ptr_q),
    .din (X_in),
    .dout(ram_dout)
  );

  assign X            = x_q;
  assign R_old        = zero_q ? '0 : ram_dout;
  assign sample_valid = sv_q;
  assign primed       = primed_q;

endmodule

// File: tb/tb_median_window_fifo.sv
// Bench for median_window_fifo: fixed vector table, then
// directed and random traffic against a sample-history model.
module tb_median_window_fifo;

  localparam int DL   = 32;
  localparam int WMAX = 16;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DL-1:0] X_in;
  logic          in_valid;
  logic [LW:0]   W;
  logic [DL-1:0] X;
  logic [DL-1:0] R_old;
  logic          sample_valid;
  logic          primed;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  median_window_fifo #(
    .DATA_LENGTH(DL), .WMAX(WMAX), .LOG_WMAX(LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .X_in        (X_in),
    .in_valid    (in_valid),
    .W           (W),
    .X           (X),
    .R_old       (R_old),
    .sample_valid(sample_valid),
    .primed      (primed)
  );

  typedef struct {
    bit          rst;
    int          w;
    bit          v;
    logic [31:0] x;
    bit          e_sv;
    logic [31:0] e_x;
    logic [31:0] e_r;
    bit          e_p;
  } vec_t;

  // reference model: history of accepted samples since last reset
  int          m_w;
  logic [31:0] hist[$];
  bit          m_sv;
  logic [31:0] m_x;
  logic [31:0] m_r;
  bit          m_p;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit rst, int w, bit v, logic [31:0] x);
    @(negedge clk);
    reset    = rst;
    W        = w[LW:0];
    in_valid = v;
    X_in     = x;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(bit rst, int w, bit v, logic [31:0] x);
    int k;
    if (rst) begin
      m_w = (w == 0 || w > WMAX) ? WMAX : w;
      hist.delete();
      m_sv = 0; m_x = 0; m_r = 0; m_p = 0;
    end else if (v) begin
      k = hist.size();
      m_r = (k < m_w) ? 32'd0 : hist[k - m_w];
      hist.push_back(x);
      m_sv = 1;
      m_x  = x;
      m_p  = (k + 1 >= m_w);
    end else begin
      m_sv = 0;
    end
  endtask

  task automatic step(bit rst, int w, bit v, logic [31:0] x);
    drive(rst, w, v, x);
    model_step(rst, w, v, x);
    check("sample_valid", {31'd0, sample_valid}, {31'd0, m_sv});
    check("X", X, m_x);
    check("R_old", R_old, m_r);
    check("primed", {31'd0, primed}, {31'd0, m_p});
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, int w, bit v, logic [31:0] x,
                              bit sv, logic [31:0] ex,
                              logic [31:0] er, bit p);
    vec_t t;
    t.rst = rst; t.w = w; t.v = v; t.x = x;
    t.e_sv = sv; t.e_x = ex; t.e_r = er; t.e_p = p;
    return t;
  endfunction

  initial begin
    reset = 1'b1; W = 5'd3; in_valid = 1'b0; X_in = '0;

    // W=3: 5,7,9,11,13 then a gap; then W=1: 1,2,3
    tbl.push_back(mk(1, 3, 0, 0,  0, 0,  0, 0));
    tbl.push_back(mk(0, 3, 1, 5,  1, 5,  0, 0));
    tbl.push_back(mk(0, 3, 1, 7,  1, 7,  0, 0));
    tbl.push_back(mk(0, 3, 1, 9,  1, 9,  0, 1));
    tbl.push_back(mk(0, 3, 1, 11, 1, 11, 5, 1));
    tbl.push_back(mk(0, 3, 1, 13, 1, 13, 7, 1));
    tbl.push_back(mk(0, 3, 0, 99, 0, 13, 7, 1));
    tbl.push_back(mk(1, 1, 1, 42, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  1, 1,  0, 1));
    tbl.push_back(mk(0, 1, 1, 2,  1, 2,  1, 1));
    tbl.push_back(mk(0, 1, 1, 3,  1, 3,  2, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].w, tbl[i].v, tbl[i].x);
      check("tbl_sv", {31'd0, sample_valid}, {31'd0, tbl[i].e_sv});
      check("tbl_X", X, tbl[i].e_x);
      check("tbl_R_old", R_old, tbl[i].e_r);
      check("tbl_primed", {31'd0, primed}, {31'd0, tbl[i].e_p});
    end

    // W=4 with gaps between samples
    step(1, 4, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 4, 1, 100 + i);
      for (int g = 0; g < i % 3; g++) step(0, 4, 0, $urandom);
    end

    // W=0 and W=WMAX+5 both clamp to WMAX; run past two wraps
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, $urandom);
    step(1, WMAX + 5, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 7, 1, $urandom);

    // W changes while running are ignored; reset with W=6 takes it
    step(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 6, 1, 200 + i);
    step(1, 6, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 6, 1, 300 + i);

    // reset during STEADY with a valid sample in the same cycle
    step(1, 5, 1, 32'hdead);
    for (int i = 0; i < 12; i++) step(0, 5, 1, 400 + i);

    // random traffic with occasional resets and random W
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1, $urandom_range(0, 31), $urandom_range(0, 1), $urandom);
      else
        step(0, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
             $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
